elevator_call_scheduler: RTL and testbench



---
 rtl/elevator_call_scheduler_pkg.sv | 13 +
 rtl/elevator_call_scheduler_if.sv | 34 +++
 rtl/elevator_call_scheduler_floor_mask.sv | 31 +++
 rtl/elevator_call_scheduler.sv | 125 ++++++++++++
 tb/tb_elevator_call_scheduler.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/elevator_call_scheduler_pkg.sv
// Shared sizing constants and travel-direction encoding for the elevator call scheduler.
package elevator_pkg;

   localparam int N_FLOORS = 20;
   localparam int FLOOR_W  = 5;

   typedef enum logic [1:0] {
      DIR_IDLE = 2'b00,
      DIR_UP   = 2'b01,
      DIR_DOWN = 2'b10
   } dir_t;

endpackage

// File: rtl/elevator_call_scheduler_if.sv
// Button/lamp and state-controller signal bundle around the call scheduler.
interface elevator_call_scheduler_if #(
   parameter int N       = elevator_pkg::N_FLOORS,
   parameter int FLOOR_W = elevator_pkg::FLOOR_W
);

   logic [N-1:0]       car_btn;
   logic [N-1:0]       hall_up_btn;
   logic [N-1:0]       hall_down_btn;
   logic [FLOOR_W-1:0] cur_floor;
   logic               moving;
   logic               door_open;
   logic [N-1:0]       dest_up;
   logic [N-1:0]       dest_down;
   logic               arrive;
   logic [N-1:0]       car_lamp;
   logic [N-1:0]       hall_up_lamp;
   logic [N-1:0]       hall_down_lamp;
   logic [1:0]         dir;
   logic               floor_err;

   modport master (
      output car_btn, hall_up_btn, hall_down_btn, cur_floor, moving, door_open,
      input  dest_up, dest_down, arrive, car_lamp, hall_up_lamp, hall_down_lamp,
             dir, floor_err
   );

   modport slave (
      input  car_btn, hall_up_btn, hall_down_btn, cur_floor, moving, door_open,
      output dest_up, dest_down, arrive, car_lamp, hall_up_lamp, hall_down_lamp,
             dir, floor_err
   );

endinterface

// File: rtl/elevator_call_scheduler_floor_mask.sv
// Decodes the current floor into above/below/at bit masks; all masks are zero
// for an out-of-range floor so nothing downstream can act on it.
module elevator_floor_mask #(
   parameter int N       = elevator_pkg::N_FLOORS,
   parameter int FLOOR_W = elevator_pkg::FLOOR_W
) (
   input  logic [FLOOR_W-1:0] cur_floor,
   output logic               floor_valid,
   output logic [N-1:0]       above_mask,
   output logic [N-1:0]       below_mask,
   output logic [N-1:0]       at_mask
);

   localparam logic [FLOOR_W:0] N_VAL = (FLOOR_W+1)'(N);

   logic [FLOOR_W:0] cur_ext;

   assign cur_ext     = {1'b0, cur_floor};
   assign floor_valid = (cur_ext < N_VAL);

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_bit
         localparam logic [FLOOR_W:0] IDX = (FLOOR_W+1)'(gi);
         assign above_mask[gi] = floor_valid && (IDX > cur_ext);
         assign below_mask[gi] = floor_valid && (IDX < cur_ext);
         assign at_mask[gi]    = floor_valid && (IDX == cur_ext);
      end
   endgenerate

endmodule

// File: rtl/elevator_call_scheduler.sv
// Collective (SCAN) call scheduler: latches hall/car calls, holds travel direction
// and produces destination maps plus a registered stop strobe for the controller.
module elevator_call_scheduler #(
   parameter int N       = elevator_pkg::N_FLOORS,
   parameter int FLOOR_W = elevator_pkg::FLOOR_W
) (
   input logic                      clk,
   input logic                      reset,
   elevator_call_scheduler_if.slave bus
);

   import elevator_pkg::*;

   // Top floor has no up button, ground floor has no down button.
   localparam logic [N-1:0] UP_LEGAL   = ~(N'(1) << (N - 1));
   localparam logic [N-1:0] DOWN_LEGAL = ~N'(1);

   logic [N-1:0] car_reg,       car_next;
   logic [N-1:0] hall_up_reg,   hall_up_next;
   logic [N-1:0] hall_down_reg, hall_down_next;
   dir_t         dir_reg,       dir_next;
   logic         arrive_reg,    arrive_next;
   logic         floor_err_reg, floor_err_next;

   logic         floor_valid;
   logic [N-1:0] above_mask, below_mask, at_mask;
   logic [N-1:0] calls;
   logic [N-1:0] clr_car, clr_up, clr_down;
   logic         above, below;
   logic         here_car, here_up, here_down;

   elevator_floor_mask #(
      .N       (N),
      .FLOOR_W (FLOOR_W)
   ) u_floor_mask (
      .cur_floor   (bus.cur_floor),
      .floor_valid (floor_valid),
      .above_mask  (above_mask),
      .below_mask  (below_mask),
      .at_mask     (at_mask)
   );

   assign calls     = car_reg | hall_up_reg | hall_down_reg;
   assign above     = |(calls & above_mask);
   assign below     = |(calls & below_mask);
   assign here_car  = |(car_reg & at_mask);
   assign here_up   = |(hall_up_reg & at_mask);
   assign here_down = |(hall_down_reg & at_mask);

   // Service clears only the hall call matching the direction the cab will leave in.
   always_comb begin
      clr_car  = '0;
      clr_up   = '0;
      clr_down = '0;
      if (bus.door_open) begin
         clr_car = at_mask;
         if (dir_reg != DIR_DOWN) clr_up   = at_mask;
         if (dir_reg != DIR_UP)   clr_down = at_mask;
      end
   end

   assign car_next       = (car_reg | bus.car_btn) & ~clr_car;
   assign hall_up_next   = (hall_up_reg | (bus.hall_up_btn & UP_LEGAL)) & ~clr_up;
   assign hall_down_next = (hall_down_reg | (bus.hall_down_btn & DOWN_LEGAL)) & ~clr_down;
   assign floor_err_next = floor_err_reg | ~floor_valid;

   always_comb begin
      dir_next = dir_reg;
      if (!bus.moving && !bus.door_open) begin
         case (dir_reg)
            DIR_IDLE: begin
               if (above)      dir_next = DIR_UP;
               else if (below) dir_next = DIR_DOWN;
            end
            DIR_UP: begin
               if (!above) dir_next = below ? DIR_DOWN : DIR_IDLE;
            end
            DIR_DOWN: begin
               if (!below) dir_next = above ? DIR_UP : DIR_IDLE;
            end
            default: dir_next = DIR_IDLE;
         endcase
      end
   end

   // An opposite-direction hall call only stops the cab at the end of its run.
   always_comb begin
      arrive_next = 1'b0;
      if (!bus.door_open) begin
         arrive_next = here_car
                     || ((dir_reg != DIR_DOWN) && here_up)
                     || ((dir_reg != DIR_UP)   && here_down)
                     || ((dir_reg == DIR_UP)   && !above && here_down)
                     || ((dir_reg == DIR_DOWN) && !below && here_up);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         car_reg       <= '0;
         hall_up_reg   <= '0;
         hall_down_reg <= '0;
         dir_reg       <= DIR_IDLE;
         arrive_reg    <= 1'b0;
         floor_err_reg <= 1'b0;
      end else begin
         car_reg       <= car_next;
         hall_up_reg   <= hall_up_next;
         hall_down_reg <= hall_down_next;
         dir_reg       <= dir_next;
         arrive_reg    <= arrive_next;
         floor_err_reg <= floor_err_next;
      end
   end

   assign bus.dest_up        = (dir_reg == DIR_UP)   ? (calls & above_mask) : '0;
   assign bus.dest_down      = (dir_reg == DIR_DOWN) ? (calls & below_mask) : '0;
   assign bus.arrive         = arrive_reg;
   assign bus.car_lamp       = car_reg;
   assign bus.hall_up_lamp   = hall_up_reg;
   assign bus.hall_down_lamp = hall_down_reg;
   assign bus.dir            = dir_reg;
   assign bus.floor_err      = floor_err_reg;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed scenario bench for the elevator call scheduler (N=20 floors).
module tb_elevator_call_scheduler;

   localparam int N  = 20;
   localparam int FW = 5;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   elevator_call_scheduler_if #(.N(N), .FLOOR_W(FW)) bus ();

   elevator_call_scheduler #(.N(N), .FLOOR_W(FW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic release_buttons();
      bus.car_btn       = '0;
      bus.hall_up_btn   = '0;
      bus.hall_down_btn = '0;
   endtask

   task automatic apply_reset(input logic [FW-1:0] floor);
      reset         = 1'b1;
      release_buttons();
      bus.cur_floor = floor;
      bus.moving    = 1'b0;
      bus.door_open = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset             = 1'b1;
      bus.car_btn       = '1;
      bus.hall_up_btn   = '1;
      bus.hall_down_btn = '1;
      bus.cur_floor     = 5'd0;
      bus.moving        = 1'b0;
      bus.door_open     = 1'b0;
      tick();
      tick();
      n_checks++; if (bus.car_lamp !== 20'h0) begin n_fail++; $display("FAIL reset_car_lamp got %h exp %h", bus.car_lamp, 20'h0); end
      n_checks++; if (bus.hall_up_lamp !== 20'h0) begin n_fail++; $display("FAIL reset_hall_up got %h exp %h", bus.hall_up_lamp, 20'h0); end
      n_checks++; if (bus.hall_down_lamp !== 20'h0) begin n_fail++; $display("FAIL reset_hall_down got %h exp %h", bus.hall_down_lamp, 20'h0); end
      n_checks++; if (bus.dir !== 2'b00) begin n_fail++; $display("FAIL reset_dir got %b exp 00", bus.dir); end
      n_checks++; if (bus.dest_up !== 20'h0) begin n_fail++; $display("FAIL reset_dest_up got %h exp 0", bus.dest_up); end
      n_checks++; if (bus.dest_down !== 20'h0) begin n_fail++; $display("FAIL reset_dest_down got %h exp 0", bus.dest_down); end
      n_checks++; if (bus.arrive !== 1'b0) begin n_fail++; $display("FAIL reset_arrive got %b exp 0", bus.arrive); end
      n_checks++; if (bus.floor_err !== 1'b0) begin n_fail++; $display("FAIL reset_floor_err got %b exp 0", bus.floor_err); end
      release_buttons();
      reset = 1'b0;
      $display("test_reset done: checks=%0d failures=%0d", n_checks, n_fail);
   endtask

   task automatic test_single_trip();
      apply_reset(5'd0);
      bus.car_btn = 20'h00020;
      tick();
      release_buttons();
      n_checks++; if (bus.car_lamp !== 20'h00020) begin n_fail++; $display("FAIL trip_car_lamp_set got %h exp %h", bus.car_lamp, 20'h00020); end
      tick();
      n_checks++; if (bus.dir !== 2'b01) begin n_fail++; $display("FAIL trip_dir_up got %b exp 01", bus.dir); end
      n_checks++; if (bus.dest_up !== 20'h00020) begin n_fail++; $display("FAIL trip_dest_up got %h exp %h", bus.dest_up, 20'h00020); end
      bus.moving    = 1'b1;
      bus.cur_floor = 5'd5;
      tick();
      n_checks++; if (bus.arrive !== 1'b1) begin n_fail++; $display("FAIL trip_arrive got %b exp 1", bus.arrive); end
      bus.moving    = 1'b0;
      bus.door_open = 1'b1;
      tick();
      n_checks++; if (bus.car_lamp !== 20'h0) begin n_fail++; $display("FAIL trip_car_clear got %h exp 0", bus.car_lamp); end
      n_checks++; if (bus.dest_up !== 20'h0) begin n_fail++; $display("FAIL trip_dest_up_clear got %h exp 0", bus.dest_up); end
      n_checks++; if (bus.arrive !== 1'b0) begin n_fail++; $display("FAIL trip_arrive_door got %b exp 0", bus.arrive); end
      bus.door_open = 1'b0;
      tick();
      n_checks++; if (bus.dir !== 2'b00) begin n_fail++; $display("FAIL trip_dir_idle got %b exp 00", bus.dir); end
      $display("test_single_trip done: checks=%0d failures=%0d", n_checks, n_fail);
   endtask

   task automatic test_collective();
      apply_reset(5'd3);
      bus.car_btn = 20'h00082;
      tick();
      release_buttons();
      tick();
      n_checks++; if (bus.dir !== 2'b01) begin n_fail++; $display("FAIL coll_dir_up got %b exp 01", bus.dir); end
      n_checks++; if (bus.dest_up !== 20'h00080) begin n_fail++; $display("FAIL coll_dest_up got %h exp %h", bus.dest_up, 20'h00080); end
      n_checks++; if (bus.dest_down !== 20'h0) begin n_fail++; $display("FAIL coll_dest_down_zero got %h exp 0", bus.dest_down); end
      bus.moving    = 1'b1;
      bus.cur_floor = 5'd7;
      tick();
      n_checks++; if (bus.arrive !== 1'b1) begin n_fail++; $display("FAIL coll_arrive7 got %b exp 1", bus.arrive); end
      bus.moving    = 1'b0;
      bus.door_open = 1'b1;
      tick();
      n_checks++; if (bus.car_lamp !== 20'h00002) begin n_fail++; $display("FAIL coll_car_after7 got %h exp %h", bus.car_lamp, 20'h00002); end
      bus.door_open = 1'b0;
      tick();
      n_checks++; if (bus.dir !== 2'b10) begin n_fail++; $display("FAIL coll_dir_down got %b exp 10", bus.dir); end
      n_checks++; if (bus.dest_down !== 20'h00002) begin n_fail++; $display("FAIL coll_dest_down got %h exp %h", bus.dest_down, 20'h00002); end
      n_checks++; if (bus.dest_up !== 20'h0) begin n_fail++; $display("FAIL coll_dest_up_zero got %h exp 0", bus.dest_up); end
      $display("test_collective done: checks=%0d failures=%0d", n_checks, n_fail);
   endtask

   task automatic test_skip_opposite();
      apply_reset(5'd0);
      bus.car_btn       = 20'h00100;
      bus.hall_down_btn = 20'h00010;
      tick();
      release_buttons();
      tick();
      bus.moving    = 1'b1;
      bus.cur_floor = 5'd4;
      tick();
      n_checks++; if (bus.arrive !== 1'b0) begin n_fail++; $display("FAIL skip_arrive4_up got %b exp 0", bus.arrive); end
      n_checks++; if (bus.hall_down_lamp !== 20'h00010) begin n_fail++; $display("FAIL skip_hall_down_lamp got %h exp %h", bus.hall_down_lamp, 20'h00010); end
      bus.cur_floor = 5'd8;
      tick();
      n_checks++; if (bus.arrive !== 1'b1) begin n_fail++; $display("FAIL skip_arrive8 got %b exp 1", bus.arrive); end
      bus.moving    = 1'b0;
      bus.door_open = 1'b1;
      tick();
      bus.door_open = 1'b0;
      tick();
      n_checks++; if (bus.dir !== 2'b10) begin n_fail++; $display("FAIL skip_dir_down got %b exp 10", bus.dir); end
      n_checks++; if (bus.dest_down !== 20'h00010) begin n_fail++; $display("FAIL skip_dest_down got %h exp %h", bus.dest_down, 20'h00010); end
      bus.moving    = 1'b1;
      bus.cur_floor = 5'd4;
      tick();
      n_checks++; if (bus.arrive !== 1'b1) begin n_fail++; $display("FAIL skip_arrive4_down got %b exp 1", bus.arrive); end
      $display("test_skip_opposite done: checks=%0d failures=%0d", n_checks, n_fail);
   endtask

   task automatic test_collision();
      apply_reset(5'd2);
      bus.door_open   = 1'b1;
      bus.car_btn     = 20'h00044;
      bus.hall_up_btn = 20'h00020;
      tick();
      release_buttons();
      n_checks++; if (bus.car_lamp !== 20'h00040) begin n_fail++; $display("FAIL coll_press_car got %h exp %h", bus.car_lamp, 20'h00040); end
      n_checks++; if (bus.hall_up_lamp !== 20'h00020) begin n_fail++; $display("FAIL coll_press_hall_up got %h exp %h", bus.hall_up_lamp, 20'h00020); end
      bus.door_open = 1'b0;
      $display("test_collision done: checks=%0d failures=%0d", n_checks, n_fail);
   endtask

   task automatic test_errors();
      apply_reset(5'd3);
      bus.car_btn = 20'h00400;
      tick();
      release_buttons();
      tick();
      n_checks++; if (bus.dest_up !== 20'h00400) begin n_fail++; $display("FAIL err_dest_up_before got %h exp %h", bus.dest_up, 20'h00400); end
      bus.moving    = 1'b1;
      bus.cur_floor = 5'd25;
      tick();
      n_checks++; if (bus.floor_err !== 1'b1) begin n_fail++; $display("FAIL err_floor_err_set got %b exp 1", bus.floor_err); end
      n_checks++; if (bus.arrive !== 1'b0) begin n_fail++; $display("FAIL err_arrive got %b exp 0", bus.arrive); end
      n_checks++; if (bus.dest_up !== 20'h0) begin n_fail++; $display("FAIL err_dest_up_forced got %h exp 0", bus.dest_up); end
      n_checks++; if (bus.dest_down !== 20'h0) begin n_fail++; $display("FAIL err_dest_down_forced got %h exp 0", bus.dest_down); end
      bus.moving    = 1'b0;
      bus.door_open = 1'b1;
      tick();
      n_checks++; if (bus.car_lamp !== 20'h00400) begin n_fail++; $display("FAIL err_no_clear got %h exp %h", bus.car_lamp, 20'h00400); end
      bus.door_open = 1'b0;
      bus.moving    = 1'b1;
      bus.cur_floor = 5'd3;
      tick();
      n_checks++; if (bus.floor_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b exp 1", bus.floor_err); end
      n_checks++; if (bus.dest_up !== 20'h00400) begin n_fail++; $display("FAIL err_dest_up_back got %h exp %h", bus.dest_up, 20'h00400); end
      bus.hall_up_btn   = 20'h80000;
      bus.hall_down_btn = 20'h00001;
      tick();
      release_buttons();
      n_checks++; if (bus.hall_up_lamp !== 20'h0) begin n_fail++; $display("FAIL err_illegal_up got %h exp 0", bus.hall_up_lamp); end
      n_checks++; if (bus.hall_down_lamp !== 20'h0) begin n_fail++; $display("FAIL err_illegal_down got %h exp 0", bus.hall_down_lamp); end
      apply_reset(5'd3);
      n_checks++; if (bus.floor_err !== 1'b0) begin n_fail++; $display("FAIL err_reset_clears got %b exp 0", bus.floor_err); end
      $display("test_errors done: checks=%0d failures=%0d", n_checks, n_fail);
   endtask

   initial begin
      reset = 1'b1;
      release_buttons();
      bus.cur_floor = '0;
      bus.moving    = 1'b0;
      bus.door_open = 1'b0;
      test_reset();
      test_single_trip();
      test_collective();
      test_skip_opposite();
      test_collision();
      test_errors();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
